// File: rtl/control_pkg.sv
// ============================================================================
// Module  : control_pkg
// Brief   : Shared types and constants for the bus-CPU fetch/execute controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package control_pkg;

    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_LDA = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        T5   = 3'd5,
        T6   = 3'd6,
        HALT = 3'd7
    } tstate_e;

    typedef struct packed {
        logic pcInc;
        logic pcSend;
        logic marLoad;
        logic ramSend;
        logic irLoad;
        logic irSend;
        logic aLoad;
        logic aSend;
        logic bLoad;
        logic aluSend;
        logic subtract;
        logic outLoad;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NONE = '0;

    // Last T-state that carries an active strobe for a given opcode.
    function automatic tstate_e last_exec_state(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_LDA:         last_exec_state = T5;
            OP_ADD, OP_SUB: last_exec_state = T6;
            default:        last_exec_state = T4;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_rom.sv
// ============================================================================
// Module  : control_rom
// Brief   : Combinational decode of (T-state, opcode) into the strobe word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module control_rom
    import control_pkg::*;
(
    input  tstate_e               i_state,
    input  logic [OPCODE_W-1:0]   i_opcode,
    output ctrl_word_t            o_ctrl
);

    always_comb begin
        o_ctrl = CTRL_NONE;
        case (i_state)
            T1: begin
                o_ctrl.pcSend  = 1'b1;
                o_ctrl.marLoad = 1'b1;
            end
            T2: o_ctrl.pcInc = 1'b1;
            T3: begin
                o_ctrl.ramSend = 1'b1;
                o_ctrl.irLoad  = 1'b1;
            end
            T4: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        o_ctrl.irSend  = 1'b1;
                        o_ctrl.marLoad = 1'b1;
                    end
                    OP_OUT: begin
                        o_ctrl.aSend   = 1'b1;
                        o_ctrl.outLoad = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (i_opcode)
                    OP_LDA: begin
                        o_ctrl.ramSend = 1'b1;
                        o_ctrl.aLoad   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        o_ctrl.ramSend  = 1'b1;
                        o_ctrl.bLoad    = 1'b1;
                        o_ctrl.subtract = (i_opcode == OP_SUB);
                    end
                    default: ;
                endcase
            end
            T6: begin
                if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
                    o_ctrl.aluSend  = 1'b1;
                    o_ctrl.aLoad    = 1'b1;
                    o_ctrl.subtract = (i_opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// Module  : control_sequencer
// Brief   : T-state sequencer issuing one-cycle datapath strobes for the bus CPU.
//           Optional macro VARIABLE_T_EN shortens instructions to their last
//           active T-state.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer
    import control_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pcInc,
    output logic                pcSend,
    output logic                marLoad,
    output logic                ramSend,
    output logic                irLoad,
    output logic                irSend,
    output logic                aLoad,
    output logic                aSend,
    output logic                bLoad,
    output logic                aluSend,
    output logic                subtract,
    output logic                outLoad,
    output logic [5:0]          tState,
    output logic                halted
);

    tstate_e    r_state;
    tstate_e    w_next;
    ctrl_word_t w_rom;
    ctrl_word_t w_ctrl;
    logic       w_last;

`ifdef VARIABLE_T_EN
    assign w_last = (r_state == last_exec_state(opcode));
`else
    assign w_last = (r_state == T6);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (run) begin
            case (r_state)
                IDLE: w_next = T1;
                T1:   w_next = T2;
                T2:   w_next = T3;
                T3:   w_next = T4;
                T4: begin
                    if (opcode == OP_HLT) w_next = HALT;
                    else if (w_last)      w_next = T1;
                    else                  w_next = T5;
                end
                T5:   w_next = w_last ? T1 : T6;
                T6:   w_next = T1;
                HALT: w_next = HALT;
                default: w_next = IDLE;
            endcase
        end
    end

    control_rom u_rom (
        .i_state  (r_state),
        .i_opcode (opcode),
        .o_ctrl   (w_rom)
    );

    // A stalled cycle must not apply anything, so strobes are gated by run.
    assign w_ctrl = run ? w_rom : CTRL_NONE;

    assign pcInc    = w_ctrl.pcInc;
    assign pcSend   = w_ctrl.pcSend;
    assign marLoad  = w_ctrl.marLoad;
    assign ramSend  = w_ctrl.ramSend;
    assign irLoad   = w_ctrl.irLoad;
    assign irSend   = w_ctrl.irSend;
    assign aLoad    = w_ctrl.aLoad;
    assign aSend    = w_ctrl.aSend;
    assign bLoad    = w_ctrl.bLoad;
    assign aluSend  = w_ctrl.aluSend;
    assign subtract = w_ctrl.subtract;
    assign outLoad  = w_ctrl.outLoad;

    always_comb begin
        tState = 6'b000000;
        case (r_state)
            T1: tState = 6'b000001;
            T2: tState = 6'b000010;
            T3: tState = 6'b000100;
            T4: tState = 6'b001000;
            T5: tState = 6'b010000;
            T6: tState = 6'b100000;
            default: tState = 6'b000000;
        endcase
    end

    assign halted = (r_state == HALT);

    always_comb begin
        a_one_send: assert ($onehot0({w_ctrl.pcSend, w_ctrl.ramSend, w_ctrl.irSend,
                                      w_ctrl.aSend, w_ctrl.aluSend}));
    end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module  : tb_control_sequencer
// Brief   : Directed self-checking bench for control_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;
    import control_pkg::*;

    // Strobe vector bit positions, MSB first.
    localparam logic [11:0] S_PCINC   = 12'h800;
    localparam logic [11:0] S_PCSEND  = 12'h400;
    localparam logic [11:0] S_MARLOAD = 12'h200;
    localparam logic [11:0] S_RAMSEND = 12'h100;
    localparam logic [11:0] S_IRLOAD  = 12'h080;
    localparam logic [11:0] S_IRSEND  = 12'h040;
    localparam logic [11:0] S_ALOAD   = 12'h020;
    localparam logic [11:0] S_ASEND   = 12'h010;
    localparam logic [11:0] S_BLOAD   = 12'h008;
    localparam logic [11:0] S_ALUSEND = 12'h004;
    localparam logic [11:0] S_SUB     = 12'h002;
    localparam logic [11:0] S_OUTLOAD = 12'h001;
    localparam logic [3:0]  OP_NOP    = 4'h5;

    logic       clock;
    logic       reset;
    logic       run;
    logic [3:0] opcode;
    logic       pcInc, pcSend, marLoad, ramSend, irLoad, irSend;
    logic       aLoad, aSend, bLoad, aluSend, subtract, outLoad;
    logic [5:0] tState;
    logic       halted;
    logic [11:0] w_str;

    int n_vec   = 0;
    int n_err   = 0;
    int n_pcinc = 0;

    control_sequencer dut (
        .clock    (clock),
        .reset    (reset),
        .run      (run),
        .opcode   (opcode),
        .pcInc    (pcInc),
        .pcSend   (pcSend),
        .marLoad  (marLoad),
        .ramSend  (ramSend),
        .irLoad   (irLoad),
        .irSend   (irSend),
        .aLoad    (aLoad),
        .aSend    (aSend),
        .bLoad    (bLoad),
        .aluSend  (aluSend),
        .subtract (subtract),
        .outLoad  (outLoad),
        .tState   (tState),
        .halted   (halted)
    );

    assign w_str = {pcInc, pcSend, marLoad, ramSend, irLoad, irSend,
                    aLoad, aSend, bLoad, aluSend, subtract, outLoad};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) if (pcInc) n_pcinc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] exp_strobe(input int t, input logic [3:0] op);
        logic [11:0] s;
        s = 12'h000;
        case (t)
            1: s = S_PCSEND | S_MARLOAD;
            2: s = S_PCINC;
            3: s = S_RAMSEND | S_IRLOAD;
            4: begin
                if (op == OP_LDA || op == OP_ADD || op == OP_SUB) s = S_IRSEND | S_MARLOAD;
                else if (op == OP_OUT)                             s = S_ASEND | S_OUTLOAD;
            end
            5: begin
                if (op == OP_LDA)      s = S_RAMSEND | S_ALOAD;
                else if (op == OP_ADD) s = S_RAMSEND | S_BLOAD;
                else if (op == OP_SUB) s = S_RAMSEND | S_BLOAD | S_SUB;
            end
            6: begin
                if (op == OP_ADD)      s = S_ALUSEND | S_ALOAD;
                else if (op == OP_SUB) s = S_ALUSEND | S_ALOAD | S_SUB;
            end
            default: s = 12'h000;
        endcase
        return s;
    endfunction

    function automatic int ncyc(input logic [3:0] op);
`ifdef VARIABLE_T_EN
        if (op == OP_LDA) return 5;
        if (op == OP_ADD || op == OP_SUB) return 6;
        return 4;
`else
        if (op == OP_HLT) return 4;
        return 6;
`endif
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Advance through T-states first..last of one instruction, checking each cycle.
    task automatic run_from(input logic [3:0] op, input int first, input int last);
        opcode = op;
        for (int t = first; t <= last; t++) begin
            step();
            chk($sformatf("tState op%0h T%0d", op, t), {26'd0, tState}, 32'd1 << (t - 1));
            chk($sformatf("strobes op%0h T%0d", op, t), {20'd0, w_str}, {20'd0, exp_strobe(t, op)});
        end
    endtask

    initial begin
        reset  = 1'b0;
        run    = 1'b0;
        opcode = OP_LDA;

        // Reset held across a clock edge.
        #7;
        chk("reset tState", {26'd0, tState}, 32'd0);
        chk("reset strobes", {20'd0, w_str}, 32'd0);
        chk("reset halted", {31'd0, halted}, 32'd0);
        @(negedge clock) reset = 1'b1;
        step();
        chk("idle run0 tState", {26'd0, tState}, 32'd0);

        // LDA, then SUB, then ADD; each T1 check confirms the previous wrap.
        run = 1'b1;
        run_from(OP_LDA, 1, ncyc(OP_LDA));
        run_from(OP_SUB, 1, ncyc(OP_SUB));
        run_from(OP_ADD, 1, 3);
        for (int t = 4; t <= 6; t++) begin
            step();
            chk($sformatf("ADD subtract T%0d", t), {31'd0, subtract}, 32'd0);
        end

        // Stall in T2 on an undefined opcode.
        run_from(OP_NOP, 1, 1);
        n_pcinc = 0;
        run_from(OP_NOP, 2, 2);
        run = 1'b0;
        #1;
        chk("stall pcInc drop", {31'd0, pcInc}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall tState", {26'd0, tState}, 32'h02);
            chk("stall strobes", {20'd0, w_str}, 32'd0);
        end
        run = 1'b1;
        run_from(OP_NOP, 3, ncyc(OP_NOP));
        chk("pcInc edges", n_pcinc, 32'd1);

        // OUT length: next T1 must follow after ncyc(OUT) cycles.
        run_from(OP_OUT, 1, ncyc(OP_OUT));
        run_from(OP_LDA, 1, 1);
        run_from(OP_LDA, 2, ncyc(OP_LDA));

        // Asynchronous reset mid-T5 of ADD.
        run_from(OP_ADD, 1, 5);
        #3 reset = 1'b0;
        #1;
        chk("async rst tState", {26'd0, tState}, 32'd0);
        chk("async rst strobes", {20'd0, w_str}, 32'd0);
        step();
        chk("async rst held", {26'd0, tState}, 32'd0);
        @(negedge clock) reset = 1'b1;
        run_from(OP_LDA, 1, 1);
        run_from(OP_LDA, 2, ncyc(OP_LDA));

        // HLT: enter HALT after T4, ignore run, leave only by reset.
        run_from(OP_HLT, 1, 4);
        step();
        chk("halt halted", {31'd0, halted}, 32'd1);
        chk("halt tState", {26'd0, tState}, 32'd0);
        chk("halt strobes", {20'd0, w_str}, 32'd0);
        opcode = OP_LDA;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt hold", {25'd0, halted, tState}, 32'h40);
        end
        @(negedge clock) reset = 1'b0;
        #1;
        chk("halt rst halted", {31'd0, halted}, 32'd0);
        chk("halt rst tState", {26'd0, tState}, 32'd0);
        @(negedge clock) reset = 1'b1;
        run_from(OP_LDA, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
